dpc_bp_learn_ctrl: RTL and testbench
====================================

# dpc_bp_learn_ctrl

Learn-mode controller and table-port arbiter for the bad-pixel correction table.
- Owns the write port of the manual bad-pixel table and the bad-pixel count that feed the detector's manual-skip checker.
- On request, captures one frame of auto-detected bad pixels from the detector's `auto_bp_*` stream and merges them in raster order with a host-written shadow list.
- Rewrites the table from the merged list, then commits the new count.
- Sits between the register block (host side) and `DPC_Detector`.

## Interface
Parameters:
- CNT_WIDTH, 10: coordinate width.
- MANUAL_BP_NUM, 128: table and shadow depth.
- MANUAL_BP_BIT, 7: table address and count width.
- AUTO_BP_NUM, 256: capture FIFO depth.
- AUTO_BP_BIT, 8: FIFO address width.

Ports (one clock `aclk`; reset `aresetn` is asynchronous, active-low):
- aclk  in  1  clock; the table write port is also clocked by aclk.
- aresetn  in  1  async active-low reset.
- learn_start  in  1  pulse: arm a one-frame capture.
- frame_start  in  1  detector SOF pulse.
- frame_done  in  1  detector frame_detection_done.
- auto_bp_valid  in  1  detector point valid.
- auto_bp_x / auto_bp_y  in  CNT_WIDTH  point coordinates.
- auto_bp_ready  out  1  accept point.
- host_wen  in  1  host shadow write.
- host_waddr  in  MANUAL_BP_BIT  shadow address.
- host_wdata  in  32  entry: {y[31:16], x[15:0]}, zero-extended.
- host_bp_num  in  MANUAL_BP_BIT  valid shadow entries, raster-sorted by host.
- table_wen  out  1  table write strobe.
- table_waddr  out  MANUAL_BP_BIT  table write address.
- table_wdata  out  32  table write data.
- table_bp_num  out  MANUAL_BP_BIT  count to checker.
- busy  out  1  state ≠ IDLE.
- learn_done  out  1  one-cycle pulse on commit.
- fifo_full  out  1  sticky; capture FIFO filled.
- trunc  out  1  sticky; merge exceeded table.

## Operation
- States: IDLE → ARM → CAPTURE → MERGE → COMMIT → IDLE.
- IDLE
  - host_wen writes the shadow and is forwarded to the table in the same cycle.
  - table_bp_num follows host_bp_num (pass-through), except after a commit: then it holds the merged count until the next host_wen.
  - learn_start → ARM; clears fifo_full, trunc and the FIFO.
- ARM: frame_start → CAPTURE.
- CAPTURE
  - auto_bp_ready = !fifo_full.
  - Each cycle with valid&ready pushes {y,x}; every such cycle is a distinct point.
  - Pushing the last free slot sets fifo_full.
  - frame_done → MERGE.
- MERGE
  - table_bp_num forced to 0, so the checker is disabled while entries change.
  - Two-way merge of shadow[0..host_bp_num-1] and FIFO, ascending by key {y,x}; smaller key is written first, shadow wins ties.
  - Writes go to table addresses 0,1,2… at one per cycle.
  - At 2^MANUAL_BP_BIT-1 written entries, remaining input is dropped and trunc is set.
  - Both sources exhausted → COMMIT.
- COMMIT: table_bp_num ← written count; learn_done pulses; → IDLE.
- Host writes outside IDLE are ignored.
- The shadow is never modified by a merge; every learn merges against the host list only.
- learn_start outside IDLE is ignored.
- frame_start during MERGE: no action, but the overlapping frame runs uncorrected.

## Timing
- Reset values: auto_bp_ready, table_wen, table_waddr, table_wdata, table_bp_num, busy, learn_done, fifo_full, trunc = 0; state IDLE.
- Host pass-through: table_wen/addr/data are combinational copies of host_* in IDLE. Zero latency.
- Shadow and FIFO use synchronous 1-cycle read.
- Merge primes in 2 cycles, then writes one entry per cycle.
- MERGE lasts host_bp_num + captured + 2 cycles (less if truncated). COMMIT lasts 1 cycle.
- Reset mid-MERGE: table contents undefined, table_bp_num = 0; host must rewrite.
- Empty sources: host_bp_num=0 and no captures → MERGE exits after 2 cycles, commit count 0.

## Configuration
- `DPC_BPM_DEDUP_EN` defined: on equal keys, one entry (the shadow one) is written; both sources advance.
- Without it: both entries are written, shadow first.

## Structure
- Shared package `dpc_pkg` holds:
  - state enum;
  - entry packing constants (X_LSB=0, Y_LSB=16);
  - key compare width 2*CNT_WIDTH.
- One sub-module, `dpc_bp_sync_ram`: simple dual-port, 1-cycle read. Instantiated twice, for the shadow and the FIFO.

## Test plan
- Host writes shadow {(5,2),(9,7)}, host_bp_num=2, in IDLE → table receives both writes same cycle; table_bp_num=2.
- Learn: detector points (3,1),(6,2),(1,9) → table 0..4 = (3,1),(5,2),(6,2),(9,7),(1,9) with x,y order; learn_done pulse; table_bp_num=5.
- Dedup: auto point (9,7) equals a shadow entry → with macro, count 4; without, count 5 with duplicate adjacent.
- Overflow: AUTO_BP_NUM+10 points in one frame → auto_bp_ready low after 256 accepts; fifo_full=1; merged count min(127, host+256) with trunc=1.
- host_wen during CAPTURE → shadow and table unchanged; learn_start during MERGE ignored.
- aresetn asserted mid-MERGE → all outputs 0 next cycle; state IDLE.

Source files
------------

// File: rtl/dpc_pkg.sv
// dpc_pkg: shared FSM states and table entry layout for the bad-pixel learn controller
//   ST_*           : learn controller states
//   X_LSB / Y_LSB  : bit positions of x and y inside a 32-bit table entry {y, x}
//   key_width()    : raster compare key width, {y, x} at CNT_WIDTH bits each
package dpc_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_MERGE, ST_COMMIT} state_t;
    localparam int X_LSB = 0;
    localparam int Y_LSB = 16;
    function automatic int key_width(input int cnt_width);
        return 2 * cnt_width;
    endfunction
endpackage

// File: rtl/dpc_bp_learn_ctrl_if.sv
// dpc_bp_learn_ctrl_if: detector-side bundle of the learn controller
//   auto_bp_valid/x/y/ready : auto-detected bad-pixel stream from the detector
//   table_wen/waddr/wdata   : manual table write port
//   table_bp_num            : valid entry count seen by the manual-skip checker
//   master = learn controller, slave = detector/table
interface dpc_bp_learn_ctrl_if #(
    parameter int CNT_WIDTH     = 10,
    parameter int MANUAL_BP_BIT = 7
);
    logic                     auto_bp_valid;
    logic                     auto_bp_ready;
    logic [CNT_WIDTH-1:0]     auto_bp_x;
    logic [CNT_WIDTH-1:0]     auto_bp_y;
    logic                     table_wen;
    logic [MANUAL_BP_BIT-1:0] table_waddr;
    logic [31:0]              table_wdata;
    logic [MANUAL_BP_BIT-1:0] table_bp_num;

    modport master (
        input  auto_bp_valid, auto_bp_x, auto_bp_y,
        output auto_bp_ready, table_wen, table_waddr, table_wdata, table_bp_num
    );
    modport slave (
        output auto_bp_valid, auto_bp_x, auto_bp_y,
        input  auto_bp_ready, table_wen, table_waddr, table_wdata, table_bp_num
    );
endinterface

// File: rtl/dpc_bp_sync_ram.sv
// dpc_bp_sync_ram: simple dual-port RAM, one write port, registered 1-cycle read
//   aclk        : clock
//   we/waddr/wdata : write port
//   raddr/rdata : read port, rdata valid the cycle after raddr
module dpc_bp_sync_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/dpc_bp_learn_ctrl.sv
// dpc_bp_learn_ctrl: learn-mode controller and write-port arbiter of the manual bad-pixel table
//   aclk, aresetn            : clock, async active-low reset
//   learn_start              : arm a one-frame capture of auto-detected points
//   frame_start, frame_done  : detector frame markers
//   det (master)             : auto_bp stream in, table write port and count out
//   host_wen/waddr/wdata     : host shadow-list write, forwarded to the table while idle
//   host_bp_num              : number of valid, raster-sorted shadow entries
//   busy, learn_done         : not idle / one-cycle commit pulse
//   fifo_full, trunc         : sticky capture-overflow and merge-truncation flags
// Define DPC_BPM_DEDUP_EN to write a single entry when shadow and captured keys are equal.
module dpc_bp_learn_ctrl
    import dpc_pkg::*;
#(
    parameter int CNT_WIDTH     = 10,
    parameter int MANUAL_BP_NUM = 128,
    parameter int MANUAL_BP_BIT = 7,
    parameter int AUTO_BP_NUM   = 256,
    parameter int AUTO_BP_BIT   = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     learn_start,
    input  logic                     frame_start,
    input  logic                     frame_done,
    dpc_bp_learn_ctrl_if.master      det,
    input  logic                     host_wen,
    input  logic [MANUAL_BP_BIT-1:0] host_waddr,
    input  logic [31:0]              host_wdata,
    input  logic [MANUAL_BP_BIT-1:0] host_bp_num,
    output logic                     busy,
    output logic                     learn_done,
    output logic                     fifo_full,
    output logic                     trunc
);
    localparam int KEY_W = key_width(CNT_WIDTH);
    localparam int FW    = AUTO_BP_BIT + 1;
    // write index that fills the table to its 2^MANUAL_BP_BIT-1 capacity
    localparam logic [MANUAL_BP_BIT-1:0] FILL_IDX = MANUAL_BP_BIT'((1 << MANUAL_BP_BIT) - 2);

    state_t                   st, nxt;
    logic [MANUAL_BP_BIT-1:0] ia, na, wcnt, bp_cnt;
    logic [FW-1:0]            ib, nb, wp;
    logic [1:0]               pcnt;
    logic                     hold, push, a_ok, b_ok, take_a, adv_a, adv_b, wr, last, trunc_set;
    logic [31:0]              sq, fq;
    logic [KEY_W-1:0]         a_key, b_key;

    // read addresses follow the next head index so sq/fq always hold the current heads
    dpc_bp_sync_ram #(.DEPTH(MANUAL_BP_NUM), .AW(MANUAL_BP_BIT), .DW(32)) u_shadow (
        .aclk,
        .we    (st == ST_IDLE && host_wen),
        .waddr (host_waddr),
        .wdata (host_wdata),
        .raddr (na),
        .rdata (sq)
    );

    dpc_bp_sync_ram #(.DEPTH(AUTO_BP_NUM), .AW(AUTO_BP_BIT), .DW(32)) u_fifo (
        .aclk,
        .we    (push),
        .waddr (wp[AUTO_BP_BIT-1:0]),
        .wdata ({16'(det.auto_bp_y), 16'(det.auto_bp_x)}),
        .raddr (nb[AUTO_BP_BIT-1:0]),
        .rdata (fq)
    );

    always_comb begin
        a_key  = {sq[Y_LSB +: CNT_WIDTH], sq[X_LSB +: CNT_WIDTH]};
        b_key  = {fq[Y_LSB +: CNT_WIDTH], fq[X_LSB +: CNT_WIDTH]};
        a_ok   = ia < host_bp_num;
        b_ok   = ib < wp;
        push   = st == ST_CAPTURE && !fifo_full && det.auto_bp_valid;
        wr     = st == ST_MERGE && pcnt == 2'd2 && (a_ok || b_ok);
        take_a = a_ok && (!b_ok || a_key <= b_key);
        adv_a  = wr && take_a;
`ifdef DPC_BPM_DEDUP_EN
        adv_b  = wr && (!take_a || (b_ok && a_key == b_key));
`else
        adv_b  = wr && !take_a;
`endif
        na        = ia + MANUAL_BP_BIT'(adv_a);
        nb        = ib + FW'(adv_b);
        // exhaustion is judged after this cycle's advance so the last write ends MERGE
        last      = na >= host_bp_num && nb >= wp;
        trunc_set = wr && !last && wcnt == FILL_IDX;
        nxt = st;
        unique case (st)
            ST_IDLE:    nxt = learn_start ? ST_ARM : st;
            ST_ARM:     nxt = frame_start ? ST_CAPTURE : st;
            ST_CAPTURE: nxt = frame_done ? ST_MERGE : st;
            ST_MERGE:   nxt = (pcnt != 2'd0 && last) || trunc_set ? ST_COMMIT : st;
            ST_COMMIT:  nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
        det.auto_bp_ready = st == ST_CAPTURE && !fifo_full;
        det.table_wen     = st == ST_IDLE ? host_wen : wr;
        det.table_waddr   = st == ST_IDLE ? (host_wen ? host_waddr : '0) : (wr ? wcnt : '0);
        det.table_wdata   = st == ST_IDLE ? (host_wen ? host_wdata : '0) : (wr ? (take_a ? sq : fq) : '0);
        // zero during MERGE keeps the checker off while entries are rewritten
        det.table_bp_num  = st == ST_MERGE ? '0 : st == ST_COMMIT ? wcnt : hold ? bp_cnt : host_bp_num;
        busy       = st != ST_IDLE;
        learn_done = st == ST_COMMIT;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) st <= ST_IDLE;
        else          st <= nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ia        <= '0;
            ib        <= '0;
            wp        <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            fifo_full <= 1'b0;
            trunc     <= 1'b0;
            hold      <= 1'b1;
            bp_cnt    <= '0;
        end else begin
            if (st == ST_IDLE && learn_start) begin
                wp        <= '0;
                fifo_full <= 1'b0;
                trunc     <= 1'b0;
            end
            if (push) begin
                wp <= wp + FW'(1);
                if (wp == FW'(AUTO_BP_NUM - 1)) fifo_full <= 1'b1;
            end
            ia   <= st == ST_MERGE ? na : '0;
            ib   <= st == ST_MERGE ? nb : '0;
            wcnt <= st == ST_MERGE ? wcnt + MANUAL_BP_BIT'(wr) : '0;
            pcnt <= st != ST_MERGE ? 2'd0 : pcnt == 2'd2 ? pcnt : pcnt + 2'd1;
            if (trunc_set) trunc <= 1'b1;
            if (st == ST_COMMIT) begin
                hold   <= 1'b1;
                bp_cnt <= wcnt;
            end else if (st == ST_IDLE && host_wen) begin
                hold <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dpc_bp_learn_ctrl.sv
// tb_dpc_bp_learn_ctrl: directed self-checking bench for dpc_bp_learn_ctrl
module tb_dpc_bp_learn_ctrl;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        learn_start = 1'b0, frame_start = 1'b0, frame_done = 1'b0;
    logic        host_wen = 1'b0;
    logic [6:0]  host_waddr = '0, host_bp_num = '0;
    logic [31:0] host_wdata = '0;
    logic        busy, learn_done, fifo_full, trunc;
    logic [31:0] tbl [128];
    int          n_chk = 0, n_fail = 0;
    int          ex1 [5] = '{3, 5, 6, 9, 1};
    int          ey1 [5] = '{1, 2, 2, 7, 9};

    dpc_bp_learn_ctrl_if dif();

    dpc_bp_learn_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .learn_start (learn_start),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .det         (dif),
        .host_wen    (host_wen),
        .host_waddr  (host_waddr),
        .host_wdata  (host_wdata),
        .host_bp_num (host_bp_num),
        .busy        (busy),
        .learn_done  (learn_done),
        .fifo_full   (fifo_full),
        .trunc       (trunc)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (dif.table_wen) tbl[dif.table_waddr] <= dif.table_wdata;

    function automatic logic [31:0] pt(input int x, input int y);
        return {y[15:0], x[15:0]};
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, learn_done, 0);
        chk({tag, "_full"}, fifo_full, 0);
        chk({tag, "_trunc"}, trunc, 0);
        chk({tag, "_ready"}, dif.auto_bp_ready, 0);
        chk({tag, "_wen"}, dif.table_wen, 0);
        chk({tag, "_waddr"}, dif.table_waddr, 0);
        chk({tag, "_wdata"}, dif.table_wdata, 0);
        chk({tag, "_bpnum"}, dif.table_bp_num, 0);
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        host_wen = 1'b1;
        host_waddr = 7'(a);
        host_wdata = d;
        #1;
        chk("host_fwd_wen", dif.table_wen, 1);
        chk("host_fwd_addr", dif.table_waddr, 7'(a));
        chk("host_fwd_data", dif.table_wdata, d);
        tick;
        host_wen = 1'b0;
    endtask

    task automatic learn_begin;
        learn_start = 1'b1;
        tick;
        learn_start = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic push(input int x, input int y);
        dif.auto_bp_x = 10'(x);
        dif.auto_bp_y = 10'(y);
        dif.auto_bp_valid = 1'b1;
        tick;
        dif.auto_bp_valid = 1'b0;
    endtask

    // ends the frame and waits for the commit; a learn_start inside MERGE must be ignored
    task automatic finish_frame(output int cyc);
        frame_done = 1'b1;
        tick;
        frame_done = 1'b0;
        cyc = 0;
        while (!learn_done && cyc < 400) begin
            if (cyc == 1) begin
                chk("bp_num_in_merge", dif.table_bp_num, 0);
                learn_start = 1'b1;
            end
            tick;
            learn_start = 1'b0;
            cyc++;
        end
        chk("learn_done_seen", learn_done, 1);
    endtask

    initial begin
        int cyc, acc, n2;
        dif.auto_bp_valid = 1'b0;
        dif.auto_bp_x = '0;
        dif.auto_bp_y = '0;
        #12;
        chk_zero("reset");
        aresetn = 1'b1;
        tick;

        host_bp_num = 7'd2;
        host_write(0, pt(5, 2));
        host_write(1, pt(9, 7));
        chk("bp_num_pass", dif.table_bp_num, 2);

        learn_begin;
        chk("ready_capture", dif.auto_bp_ready, 1);
        push(3, 1);
        push(6, 2);
        push(1, 9);
        finish_frame(cyc);
        chk("merge_cycles_1", cyc, 7);
        chk("commit_cnt_1", dif.table_bp_num, 5);
        tick;
        chk("done_pulse", learn_done, 0);
        chk("idle_after_commit", busy, 0);
        chk("bp_num_hold", dif.table_bp_num, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("tbl1_%0d", i), tbl[i], pt(ex1[i], ey1[i]));

        learn_begin;
        push(3, 1);
        host_wen = 1'b1;
        host_waddr = 7'd0;
        host_wdata = pt(100, 100);
        #1;
        chk("host_blocked", dif.table_wen, 0);
        tick;
        host_wen = 1'b0;
        push(9, 7);
        push(1, 9);
        finish_frame(cyc);
`ifdef DPC_BPM_DEDUP_EN
        n2 = 4;
`else
        n2 = 5;
`endif
        chk("merge_cycles_2", cyc, n2 + 2);
        chk("commit_cnt_2", dif.table_bp_num, n2);
        tick;
        chk("tbl2_0", tbl[0], pt(3, 1));
        chk("tbl2_1", tbl[1], pt(5, 2));
        chk("tbl2_2", tbl[2], pt(9, 7));
        chk("tbl2_3", tbl[3], n2 == 5 ? pt(9, 7) : pt(1, 9));

        learn_begin;
        acc = 0;
        for (int i = 0; i < 266; i++) begin
            dif.auto_bp_x = 10'(i);
            dif.auto_bp_y = 10'd20;
            dif.auto_bp_valid = 1'b1;
            acc += int'(dif.auto_bp_ready);
            tick;
        end
        dif.auto_bp_valid = 1'b0;
        chk("accepted", acc, 256);
        chk("fifo_full", fifo_full, 1);
        chk("ready_when_full", dif.auto_bp_ready, 0);
        finish_frame(cyc);
        chk("merge_cycles_ovf", cyc, 129);
        chk("commit_cnt_ovf", dif.table_bp_num, 127);
        chk("trunc_set", trunc, 1);
        tick;
        chk("tbl3_0", tbl[0], pt(5, 2));
        chk("tbl3_2", tbl[2], pt(0, 20));
        chk("tbl3_126", tbl[126], pt(124, 20));

        host_bp_num = 7'd0;
        learn_begin;
        chk("trunc_cleared", trunc, 0);
        chk("full_cleared", fifo_full, 0);
        finish_frame(cyc);
        chk("merge_cycles_empty", cyc, 2);
        chk("commit_cnt_empty", dif.table_bp_num, 0);
        tick;

        host_bp_num = 7'd2;
        learn_begin;
        push(3, 1);
        push(6, 2);
        frame_done = 1'b1;
        tick;
        frame_done = 1'b0;
        tick;
        chk("busy_in_merge", busy, 1);
        aresetn = 1'b0;
        #1;
        chk_zero("mid_merge_rst");
        tick;
        aresetn = 1'b1;
        tick;
        chk("bp_num_after_rst", dif.table_bp_num, 0);
        chk("idle_after_rst", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
